// File: rtl/div_unit_pkg.sv
// Shared definitions for the iterative divider: op-select bit positions,
// FSM state encoding and the divide-by-zero quotient.
package div_unit_pkg;

    localparam int DIV_W  = 0;
    localparam int MOD_W  = 1;
    localparam int DIV_WU = 2;
    localparam int MOD_WU = 3;

    localparam logic [31:0] DIV_ZERO_Q = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    // Two's-complement negate when neg is set, pass-through otherwise.
    function automatic logic [31:0] cond_neg(input logic [31:0] value, input logic neg);
        return neg ? (~value + 32'd1) : value;
    endfunction

endpackage

// File: rtl/div_step.sv
// One combinational restoring-division iteration: shift remainder:quotient
// left, trial-subtract the divisor and either keep the difference or restore.
module div_step
    import div_unit_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W:0]   rem_in,
    input  logic [DATA_W-1:0] quo_in,
    input  logic [DATA_W-1:0] divisor,
    output logic [DATA_W:0]   rem_out,
    output logic [DATA_W-1:0] quo_out
);

    logic [DATA_W+1:0] trial;
    logic              borrow;

    // The extra top bit of trial captures the borrow of the subtraction.
    always_comb begin
        trial   = {rem_in, quo_in[DATA_W-1]} - {2'b00, divisor};
        borrow  = trial[DATA_W+1];
        rem_out = borrow ? {rem_in[DATA_W-1:0], quo_in[DATA_W-1]} : trial[DATA_W:0];
        quo_out = {quo_in[DATA_W-2:0], ~borrow};
    end

endmodule

// File: rtl/div_unit.sv
// Multi-cycle restoring divider for div.w / mod.w / div.wu / mod.wu with a
// valid/ready handshake on both sides and a flush that aborts in-flight work.
module div_unit
    import div_unit_pkg::*;
#(
    parameter int DATA_W          = 32,
    parameter int STEPS_PER_CYCLE = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              div_valid,
    output logic              div_ready,
    input  logic [3:0]        div_op,
    input  logic [DATA_W-1:0] div_src1,
    input  logic [DATA_W-1:0] div_src2,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] div_result
);

    localparam logic [5:0] COUNT_INIT = 6'(DATA_W / STEPS_PER_CYCLE);

    state_t state, state_next;

    logic [5:0]        count;
    logic [DATA_W:0]   rem;
    logic [DATA_W-1:0] quo;
    logic [DATA_W-1:0] divisor;
    logic [DATA_W-1:0] src1_raw;
    logic              want_rem;
    logic              neg_q;
    logic              neg_r;
    logic              div_zero;

    logic              accept;
    logic              op_signed;
    logic              op_rem;
    logic              src1_neg;
    logic              src2_neg;
    logic [DATA_W-1:0] src1_abs;
    logic [DATA_W-1:0] src2_abs;
    logic [DATA_W-1:0] q_final;
    logic [DATA_W-1:0] r_final;
    logic [DATA_W-1:0] result_next;

    logic [DATA_W:0]   rem_chain [STEPS_PER_CYCLE+1];
    logic [DATA_W-1:0] quo_chain [STEPS_PER_CYCLE+1];

    assign div_ready = (state == IDLE);
    assign out_valid = (state == DONE);
    assign accept    = div_valid & div_ready & ~flush;

    // Decode the one-hot op and take operand magnitudes; the remainder is
    // selected only when a mod bit is set and no div bit is.
    always_comb begin
        op_signed = div_op[DIV_W] | div_op[MOD_W];
        op_rem    = (div_op[MOD_W] | div_op[MOD_WU]) & ~(div_op[DIV_W] | div_op[DIV_WU]);
        src1_neg  = op_signed & div_src1[DATA_W-1];
        src2_neg  = op_signed & div_src2[DATA_W-1];
        src1_abs  = cond_neg(div_src1, src1_neg);
        src2_abs  = cond_neg(div_src2, src2_neg);
    end

    assign rem_chain[0] = rem;
    assign quo_chain[0] = quo;

    for (genvar g = 0; g < STEPS_PER_CYCLE; g++) begin : g_step
        div_step #(
            .DATA_W (DATA_W)
        ) u_step (
            .rem_in  (rem_chain[g]),
            .quo_in  (quo_chain[g]),
            .divisor (divisor),
            .rem_out (rem_chain[g+1]),
            .quo_out (quo_chain[g+1])
        );
    end

    // Sign fix-up on the last iteration's output; a zero divisor overrides it.
    always_comb begin
        q_final = cond_neg(quo_chain[STEPS_PER_CYCLE], neg_q);
        r_final = cond_neg(rem_chain[STEPS_PER_CYCLE][DATA_W-1:0], neg_r);
        if (div_zero) begin
            result_next = want_rem ? src1_raw : DIV_ZERO_Q;
        end else begin
            result_next = want_rem ? r_final : q_final;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Flush wins over both accept and the result handshake.
    always_comb begin
        state_next = state;
        if (flush) begin
            state_next = IDLE;
        end else begin
            unique case (state)
                IDLE: if (accept) state_next = BUSY;
                BUSY: if (count == 6'd1) state_next = DONE;
                DONE: if (out_ready) state_next = IDLE;
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count      <= '0;
            rem        <= '0;
            quo        <= '0;
            divisor    <= '0;
            src1_raw   <= '0;
            want_rem   <= 1'b0;
            neg_q      <= 1'b0;
            neg_r      <= 1'b0;
            div_zero   <= 1'b0;
            div_result <= '0;
        end else if (flush) begin
            count <= '0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (accept) begin
                        count    <= COUNT_INIT;
                        rem      <= '0;
                        quo      <= src1_abs;
                        divisor  <= src2_abs;
                        src1_raw <= div_src1;
                        want_rem <= op_rem;
                        neg_q    <= src1_neg ^ src2_neg;
                        neg_r    <= src1_neg;
                        div_zero <= (div_src2 == '0);
                    end
                end
                BUSY: begin
                    rem   <= rem_chain[STEPS_PER_CYCLE];
                    quo   <= quo_chain[STEPS_PER_CYCLE];
                    count <= count - 6'd1;
                    if (count == 6'd1) begin
                        div_result <= result_next;
                    end
                end
                default: ;
            endcase
        end
    end

    always @(posedge clk) begin
        if (!reset && accept) begin
            assert ($onehot(div_op));
        end
    end

endmodule

// File: tb/tb_div_unit.sv
// Directed bench for div_unit: one instance per legal STEPS_PER_CYCLE share
// the stimulus, so each vector checks both the 32- and 16-cycle variants.
module tb_div_unit;

    localparam logic [3:0] OP_DIV_W  = 4'b0001;
    localparam logic [3:0] OP_MOD_W  = 4'b0010;
    localparam logic [3:0] OP_DIV_WU = 4'b0100;
    localparam logic [3:0] OP_MOD_WU = 4'b1000;

    logic        clk       = 1'b0;
    logic        reset     = 1'b1;
    logic        div_valid = 1'b0;
    logic [3:0]  div_op    = OP_DIV_W;
    logic [31:0] div_src1  = 32'd0;
    logic [31:0] div_src2  = 32'd1;
    logic        flush     = 1'b0;
    logic        out_ready = 1'b0;

    logic        ready1, valid1, ready2, valid2;
    logic [31:0] result1, result2;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    div_unit #(.DATA_W(32), .STEPS_PER_CYCLE(1)) dut1 (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (ready1),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .flush      (flush),
        .out_valid  (valid1),
        .out_ready  (out_ready),
        .div_result (result1)
    );

    div_unit #(.DATA_W(32), .STEPS_PER_CYCLE(2)) dut2 (
        .clk        (clk),
        .reset      (reset),
        .div_valid  (div_valid),
        .div_ready  (ready2),
        .div_op     (div_op),
        .div_src1   (div_src1),
        .div_src2   (div_src2),
        .flush      (flush),
        .out_valid  (valid2),
        .out_ready  (out_ready),
        .div_result (result2)
    );

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        tests++;
        assert (observed === expected) else begin
            fails++;
            $error("[TB] FAIL %s: observed 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic apply_stimulus(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
        div_valid = 1'b1;
        div_op    = op;
        div_src1  = a;
        div_src2  = b;
    endtask

    // Issue one op, measure both latencies, optionally hold backpressure, then handshake.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] expected, input int hold);
        int lat1 = 0;
        int lat2 = 0;
        check_output({tag, " ready1 idle"}, {31'd0, ready1}, 32'd1);
        check_output({tag, " ready2 idle"}, {31'd0, ready2}, 32'd1);
        apply_stimulus(op, a, b);
        for (int i = 0; i <= 40 && lat1 == 0; i++) begin
            @(posedge clk); #1;
            if (i == 0) begin
                div_valid = 1'b0;
                div_src1  = 32'hDEAD_BEEF;
                div_src2  = 32'h0000_0003;
                check_output({tag, " ready1 busy"}, {31'd0, ready1}, 32'd0);
            end
            if (valid2 && lat2 == 0) begin
                lat2 = i;
                check_output({tag, " result2"}, result2, expected);
            end
            if (valid1) lat1 = i;
        end
        check_output({tag, " latency1"}, 32'(lat1), 32'd32);
        check_output({tag, " latency2"}, 32'(lat2), 32'd16);
        check_output({tag, " result1"}, result1, expected);
        check_output({tag, " result2 held"}, result2, expected);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
            check_output({tag, " bp valid1"}, {31'd0, valid1}, 32'd1);
            check_output({tag, " bp result1"}, result1, expected);
            check_output({tag, " bp ready1"}, {31'd0, ready1}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        check_output({tag, " valid1 drop"}, {31'd0, valid1}, 32'd0);
        check_output({tag, " ready1 after"}, {31'd0, ready1}, 32'd1);
        check_output({tag, " ready2 after"}, {31'd0, ready2}, 32'd1);
    endtask

    // Flush after 'when' edges past the accept edge; no result may appear afterwards.
    task automatic flush_case(input string tag, input int when);
        logic seen = 1'b0;
        apply_stimulus(OP_DIV_W, 32'd7, 32'hFFFF_FFFE);
        for (int i = 0; i <= when; i++) begin
            @(posedge clk); #1;
            if (i == 0) div_valid = 1'b0;
            seen = seen | valid1;
        end
        flush     = 1'b1;
        div_valid = 1'b1;
        @(posedge clk); #1;
        check_output({tag, " ready1 flushed"}, {31'd0, ready1}, 32'd1);
        check_output({tag, " ready2 flushed"}, {31'd0, ready2}, 32'd1);
        check_output({tag, " valid2 flushed"}, {31'd0, valid2}, 32'd0);
        @(posedge clk); #1;
        check_output({tag, " flush beats accept"}, {31'd0, ready1}, 32'd1);
        flush     = 1'b0;
        div_valid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | valid1 | valid2;
        end
        check_output({tag, " no result"}, {31'd0, seen}, 32'd0);
    endtask

    initial begin
        logic seen;
        repeat (2) @(posedge clk);
        #1;
        check_output("reset ready1", {31'd0, ready1}, 32'd1);
        check_output("reset ready2", {31'd0, ready2}, 32'd1);
        check_output("reset valid1", {31'd0, valid1}, 32'd0);
        check_output("reset result1", result1, 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        run_op("div.w 7/-2",       OP_DIV_W,  32'd7,          32'hFFFF_FFFE, 32'hFFFF_FFFD, 0);
        run_op("mod.w 7/-2",       OP_MOD_W,  32'd7,          32'hFFFF_FFFE, 32'h0000_0001, 0);
        run_op("mod.w -7/2",       OP_MOD_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 0);
        run_op("div.w -7/2",       OP_DIV_W,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 0);
        run_op("div.wu max/16",    OP_DIV_WU, 32'hFFFF_FFFF, 32'h10,        32'h0FFF_FFFF, 0);
        run_op("mod.wu max/16",    OP_MOD_WU, 32'hFFFF_FFFF, 32'h10,        32'h0000_000F, 5);
        run_op("div.w 5/0",        OP_DIV_W,  32'd5,          32'd0,         32'hFFFF_FFFF, 0);
        run_op("mod.wu 5/0",       OP_MOD_WU, 32'd5,          32'd0,         32'h0000_0005, 0);
        run_op("mod.w -7/0",       OP_MOD_W,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 0);
        run_op("div.w ovf",        OP_DIV_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 0);
        run_op("mod.w ovf",        OP_MOD_W,  32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 0);

        flush_case("flush cnt2=10", 6);
        run_op("div.wu 100/7 a",   OP_DIV_WU, 32'd100,        32'd7,         32'h0000_000E, 0);
        flush_case("flush cnt1=10", 22);
        run_op("div.wu 100/7 b",   OP_DIV_WU, 32'd100,        32'd7,         32'h0000_000E, 0);

        apply_stimulus(OP_DIV_W, 32'd1000, 32'd3);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            if (i == 0) div_valid = 1'b0;
        end
        reset = 1'b1;
        #1;
        check_output("midreset ready1", {31'd0, ready1}, 32'd1);
        check_output("midreset ready2", {31'd0, ready2}, 32'd1);
        check_output("midreset result1", result1, 32'd0);
        check_output("midreset result2", result2, 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen  = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            seen = seen | valid1 | valid2;
        end
        check_output("midreset no result", {31'd0, seen}, 32'd0);
        run_op("div.wu 100/7 c",   OP_DIV_WU, 32'd100,        32'd7,         32'h0000_000E, 0);
        run_op("mod.wu 100/7",     OP_MOD_WU, 32'd100,        32'd7,         32'h0000_0002, 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/div_unit.md
Name: div_unit

Overview:
- Multi-cycle iterative divider for the EX stage; executes div.w, mod.w, div.wu and mod.wu.
- Complements the single-cycle ALU, which has no divider.
- The EX stage issues one operation through a valid/ready handshake and stalls until the result handshake completes.
- A flush input aborts an in-flight operation on exception or branch redirect.

Parameters:
- DATA_W, 32, operand and result width; only 32 is supported.
- STEPS_PER_CYCLE, 1, restoring-division iterations per clock; legal values are 1 and 2.

Ports:
- clk  in  1  system clock.
- reset  in  1  asynchronous, active-high reset.
- div_valid  in  1  EX stage offers an operation.
- div_ready  out  1  unit can accept an operation.
- div_op  in  4  one-hot operation select: [0] div.w, [1] mod.w, [2] div.wu, [3] mod.wu.
- div_src1  in  32  dividend (rj).
- div_src2  in  32  divisor (rk).
- flush  in  1  abort the current operation.
- out_valid  out  1  result is available.
- out_ready  in  1  consumer takes the result.
- div_result  out  32  quotient or remainder, as selected by div_op.

Behaviour:
- One clock. Reset is asynchronous and active-high; all state is in the clk domain.
- Reset values:
  - state = IDLE, count = 0, out_valid = 0, div_result = 0.
  - div_ready = 1 whenever state is IDLE, including while reset is held.
- FSM states: IDLE, BUSY, DONE.
- div_ready is 1 only in IDLE.
- Accept: div_valid & div_ready & ~flush at edge k.
  - Latch the op, sign flags and absolute values of the operands (signed ops only).
  - Clear the partial remainder; set count = 32/STEPS_PER_CYCLE.
  - Go to BUSY.
- BUSY: each edge performs STEPS_PER_CYCLE restoring steps:
  - shift remainder:quotient left by 1;
  - trial-subtract the divisor;
  - set the quotient LSB if no borrow, otherwise restore.
  - count decrements; at count reaching 0, go to DONE.
- Latency: out_valid is high after edge k+32/STEPS_PER_CYCLE (32 cycles at the default). Latency is fixed and independent of the operand values.
- Sign fix-up, applied when entering DONE and registered into div_result:
  - quotient is negated iff the op is signed and src1[31] ^ src2[31];
  - remainder is negated iff the op is signed and src1[31];
  - unsigned ops apply no fix-up.
- Divisor = 0 (any op) overrides the computed result: quotient = 0xFFFFFFFF, remainder = src1 unchanged. The operation still takes the full latency.
- Signed overflow (0x80000000 / 0xFFFFFFFF) needs no special case: quotient = 0x80000000, remainder = 0, produced by the normal datapath with 33-bit magnitude handling.
- DONE:
  - out_valid = 1; div_result is held stable until out_ready.
  - On out_valid & out_ready, go to IDLE; out_valid = 0 at the next edge.
  - No new accept occurs in the same cycle, which gives a one-cycle bubble.
- Flush:
  - In any state, the next edge forces IDLE, out_valid = 0 and count = 0.
  - Flush has priority over accept and over the result handshake.
  - A flushed result is never presented.
- div_valid outside IDLE is ignored. div_src1, div_src2 and div_op are sampled only at the accept edge.
- Reset asserted mid-operation returns to the reset values immediately (asynchronously); no result is produced.
- div_op not one-hot (0 or multiple bits set): behaviour is undefined; an assertion fires in simulation.

Decomposition:
- Shared package holds:
  - op bit indices DIV_W = 0, MOD_W = 1, DIV_WU = 2, MOD_WU = 3;
  - state encodings IDLE, BUSY, DONE;
  - constant DIV_ZERO_Q = 32'hFFFFFFFF.
- Sub-module div_step: one combinational restoring iteration.
  - Inputs: 33-bit remainder, 32-bit quotient, 32-bit divisor.
  - Outputs: next remainder, next quotient.
  - Instantiated STEPS_PER_CYCLE times in a chain inside div_unit.
- The FSM, counter, sign fix-up and output register live in div_unit.

Test Plan:
- div.w 7 / 0xFFFFFFFE (-2) -> out_valid exactly 32 cycles after the accept edge, div_result 0xFFFFFFFD; mod.w with the same operands -> 0x00000001.
- mod.w 0xFFFFFFF9 (-7) % 2 -> 0xFFFFFFFF; div.wu 0xFFFFFFFF / 0x10 -> 0x0FFFFFFF; mod.wu same operands -> 0x0000000F.
- Divide by zero: div.w 5 / 0 -> 0xFFFFFFFF; mod.wu 5 % 0 -> 0x00000005; both after the full 32-cycle latency.
- Overflow: div.w 0x80000000 / 0xFFFFFFFF -> 0x80000000; mod.w same operands -> 0x00000000.
- Backpressure: hold out_ready = 0 for 5 cycles in DONE -> out_valid and div_result stable, div_ready = 0 throughout; on the handshake, div_ready = 1 the following cycle; back-to-back ops give correct results.
- Flush in BUSY at count = 10, and separately reset asserted mid-BUSY -> out_valid never rises, div_ready = 1 after the next edge; a following div.wu 100 / 7 returns 0x0000000E. Repeat all cases with STEPS_PER_CYCLE = 2 and check 16-cycle latency.
